switch_scan_scheduler: RTL and testbench

//  Debounces NUM_SW push-buttons/switches by time-sharing one prescaler and one

---
 rtl/switch_scan_scheduler.sv | 92 +++++++++
 tb/tb_switch_scan_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/switch_scan_scheduler.sv
// Time-shared switch debouncer: one prescaler and one evaluation datapath
// visit every switch round-robin once per sample tick.
module switch_scan_scheduler #(
    parameter int NUM_SW       = 4,
    parameter int TICK_DIV     = 25000,
    parameter int STABLE_TICKS = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Switch,
    output logic [NUM_SW-1:0] o_Press,
    output logic [NUM_SW-1:0] o_Release,
    output logic [NUM_SW-1:0] o_LED,
    output logic [3:0]        o_Scan_Idx
);
    localparam int IW = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state;
    logic [NUM_SW-1:0] sync_a, sync_b;
    logic [PW-1:0]     presc;
    logic              tick;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt [NUM_SW];
    logic              busy;
    logic              cur_raw;
    logic              cur_sw;
    logic [CW:0]       cnt_nxt;

    assign busy       = (state == SCAN);
    assign cur_raw    = sync_b[idx];
    assign cur_sw     = o_Switch[idx];
    assign cnt_nxt    = {1'b0, cnt[idx]} + 1'b1;
    assign o_Scan_Idx = 4'(idx);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            sync_a    <= '0;
            sync_b    <= '0;
            presc     <= '0;
            tick      <= 1'b0;
            idx       <= '0;
            o_Switch  <= '0;
            o_Press   <= '0;
            o_Release <= '0;
            o_LED     <= '0;
            for (int k = 0; k < NUM_SW; k++) cnt[k] <= '0;
        end else begin
            sync_a    <= i_Switch;
            sync_b    <= sync_a;
            presc     <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
            tick      <= (presc == PW'(TICK_DIV - 1));
            o_Press   <= '0;
            o_Release <= '0;

            if (!busy) begin
                if (tick) begin
                    state <= SCAN;
                    idx   <= '0;
                end
            end else begin
                // A sample agreeing with the stable state restarts the window.
                if (cur_raw == cur_sw) begin
                    cnt[idx] <= '0;
                end else if (cnt_nxt < (CW+1)'(STABLE_TICKS)) begin
                    cnt[idx] <= cnt_nxt[CW-1:0];
                end else begin
                    cnt[idx]      <= '0;
                    o_Switch[idx] <= cur_raw;
                    if (cur_raw) begin
                        o_Press[idx] <= 1'b1;
                        o_LED[idx]   <= ~o_LED[idx];
                    end else begin
                        o_Release[idx] <= 1'b1;
                    end
                end

                if (idx == IW'(NUM_SW - 1)) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_switch_scan_scheduler.sv
// Bench for switch_scan_scheduler: directed scenarios plus random switch activity,
// checked every cycle against a schedule-arithmetic reference model.
module tb_switch_scan_scheduler;
    localparam int NSW = 4;
    localparam int TD  = 8;
    localparam int ST  = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] i_Switch = '0;
    logic [3:0] o_Switch, o_Press, o_Release, o_LED, o_Scan_Idx;

    switch_scan_scheduler #(.NUM_SW(NSW), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
        .CLK(CLK), .RST(RST), .i_Switch(i_Switch), .o_Switch(o_Switch),
        .o_Press(o_Press), .o_Release(o_Release), .o_LED(o_LED), .o_Scan_Idx(o_Scan_Idx)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: n counts clock edges since reset release; ticks land on
    // edges n = m*TD, switch k is judged on edge m*TD+2+k using the raw value
    // sampled two edges earlier.
    int         n = 0;
    logic [3:0] r1 = '0, r2 = '0;
    logic [3:0] m_sw = '0, m_led = '0, m_press = '0, m_rel = '0, m_idx = '0;
    int         m_cnt [4];
    int         pcnt [4];
    int         rcnt [4];
    int         last_press_n [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_obs();
        for (int k = 0; k < 4; k++) begin
            pcnt[k] = 0; rcnt[k] = 0; last_press_n[k] = -1;
        end
    endtask

    task automatic step(input logic [3:0] sw, input logic rst);
        i_Switch = sw;
        RST      = rst;
        @(posedge CLK);
        #1;
        m_press = '0;
        m_rel   = '0;
        if (rst) begin
            n = 0; r1 = '0; r2 = '0; m_sw = '0; m_led = '0; m_idx = '0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else begin
            n++;
            if (n >= TD + 2 && (n - 2) % TD < NSW) begin
                int k;
                k = (n - 2) % TD;
                if (r2[k] == m_sw[k]) m_cnt[k] = 0;
                else if (m_cnt[k] + 1 < ST) m_cnt[k]++;
                else begin
                    m_cnt[k] = 0;
                    m_sw[k]  = r2[k];
                    if (r2[k]) begin
                        m_press[k] = 1'b1;
                        m_led[k]   = ~m_led[k];
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end
            end
            m_idx = (n >= TD + 1 && (n - 1) % TD < NSW) ? 4'((n - 1) % TD) : 4'd0;
            r2 = r1;
            r1 = sw;
        end
        chk("switch",  32'(o_Switch),   32'(m_sw));
        chk("press",   32'(o_Press),    32'(m_press));
        chk("release", 32'(o_Release),  32'(m_rel));
        chk("led",     32'(o_LED),      32'(m_led));
        chk("scan_idx",32'(o_Scan_Idx), 32'(m_idx));
        chk("tick_in_scan", 32'(dut.tick & dut.busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (o_Press[k])   begin pcnt[k]++; last_press_n[k] = n; end
            if (o_Release[k]) rcnt[k]++;
        end
    endtask

    initial begin
        logic [3:0] cur;
        int         g;
        clr_obs();

        // 1: reset with all switches high
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
        chk("t1_outputs", {16'd0, o_Switch, o_LED, o_Press, o_Release}, 32'd0);

        // 2: clean press on sw0
        for (int i = 0; i < 30; i++) step(4'b0001, 1'b0);
        chk("t2_led", 32'(o_LED), 32'h1);
        chk("t2_press_cnt", 32'(pcnt[0]), 32'd1);
        chk("t2_press_edge", 32'(last_press_n[0]), 32'(TD * ST + 2));

        // 3: bounce on sw1, aligned so the sampling phase is fixed
        g = 0;
        while ((n + 1) % TD != 7 && g < TD) begin step(4'b0001, 1'b0); g++; end
        clr_obs();
        for (int j = 0; j < 60; j++) step({2'b00, 1'(((j / 5) % 2) == 1), 1'b1}, 1'b0);
        for (int i = 0; i < 30; i++) step(4'b0001, 1'b0);
        chk("t3_sw1", 32'(o_Switch[1]), 32'd0);
        chk("t3_press1", 32'(pcnt[1]), 32'd0);
        chk("t3_release1", 32'(rcnt[1]), 32'd0);

        // 4: sw2 and sw3 change together
        clr_obs();
        for (int i = 0; i < 32; i++) step(4'b1101, 1'b0);
        chk("t4_order", 32'(last_press_n[3] - last_press_n[2]), 32'd1);
        chk("t4_led", 32'(o_LED[3:2]), 32'h3);
        chk("t4_switch", 32'(o_Switch), 32'hD);

        // 5: release then re-press sw0
        clr_obs();
        for (int i = 0; i < 32; i++) step(4'b1100, 1'b0);
        chk("t5_release", 32'(rcnt[0]), 32'd1);
        chk("t5_led_hold", 32'(o_LED[0]), 32'd1);
        clr_obs();
        for (int i = 0; i < 32; i++) step(4'b1101, 1'b0);
        chk("t5_repress", 32'(pcnt[0]), 32'd1);
        chk("t5_led_back", 32'(o_LED[0]), 32'd0);

        // 6: reset mid-scan while sw2 is two samples into a release
        g = 0;
        while (m_cnt[2] != 2 && g < 40) begin step(4'b1001, 1'b0); g++; end
        chk("t6_cnt_reached", 32'(g < 40), 32'd1);
        chk("t6_sw2_held", 32'(o_Switch[2]), 32'd1);
        g = 0;
        while (n % TD != 1 && g < TD) begin step(4'b1001, 1'b0); g++; end
        chk("t6_in_scan", 32'(o_Scan_Idx), 32'd0);
        step(4'b1001, 1'b1);
        step(4'b1001, 1'b1);
        chk("t6_cleared", {24'd0, o_Switch, o_LED}, 32'd0);
        clr_obs();
        for (int i = 0; i < 32; i++) step(4'b0100, 1'b0);
        chk("t6_press_edge", 32'(last_press_n[2]), 32'(TD * ST + 4));
        chk("t6_press_cnt", 32'(pcnt[2]), 32'd1);

        // random slow-changing switch activity with an occasional reset
        cur = 4'b0100;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 11) == 0) cur[$urandom_range(0, 3)] ^= 1'b1;
            step(cur, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
